sin_nco: RTL and testbench
==========================

# sin_nco

Quarter-wave-LUT sine numerically controlled oscillator that generates the unsigned offset-binary sample stream driving the first-order sigma-delta modulator's data input. A phase accumulator advances by a double-buffered frequency tuning word on each sample tick from an internal rate divider. The phase is folded into a quarter-wave ROM and unfolded to a full-scale 16-bit code. The output is held between ticks so the modulator can sample it on every clock.

## Interface
- DATA_W, 16, output sample width; ROM entries are DATA_W-1 bits
- PHASE_W, 24, phase accumulator and tuning word width
- LUT_AW, 8, quarter-wave ROM address width (2^LUT_AW entries)
- DIV_W, 8, sample-rate divider width
- LUT_FILE, "sin_quarter.hex", $readmemh image for the ROM

- nco_clk  in  1  single clock, shared with the modulator
- nco_rst  in  1  asynchronous, active-high reset
- ftw  in  PHASE_W  frequency tuning word (phase increment per tick)
- ftw_wr  in  1  one-cycle strobe; captures ftw into the shadow register
- div  in  DIV_W  tick every div+1 clocks
- phase_clr  in  1  one-cycle strobe; zeroes the phase accumulator
- ftw_pend  out  1  shadow word written, not yet applied
- nco_dout  out  DATA_W  offset-binary sine sample; mid-scale is 2^(DATA_W-1)
- nco_valid  out  1  one-cycle pulse when nco_dout takes a new sample

## Operation
- ROM contents: L[i] = round((2^(DATA_W-1)-1)*sin(pi/2*(i+0.5)/2^LUT_AW)). The half-LSB index offset removes duplicate endpoints.
- Divider: cnt counts up each clock. tick = (cnt >= div). On tick, cnt is set to 0. Using >= means lowering div mid-count never stalls. div=0 gives a tick every clock.
- On tick, stage 1 captures the current phase_q. In the same cycle, phase_q <= phase_q + ftw_act, mod 2^PHASE_W with natural wrap and the carry discarded.
- phase_clr sets phase_q to 0 at the next edge and overrides the increment. If tick is coincident, stage 1 still captures the pre-clear phase_q.
- Tuning word:
  - ftw_wr loads ftw into shadow and sets ftw_pend.
  - On tick with ftw_pend=1: ftw_act <= shadow and ftw_pend clears. The increment in that tick still uses the old ftw_act.
  - ftw_wr coincident with tick: the tick transfers the old shadow (if pending), the new word lands in shadow, and ftw_pend remains 1.
- Fold (stage 1 → 2):
  - q = phase[PHASE_W-1:PHASE_W-2]; idx = next LUT_AW bits.
  - addr = q[0] ? ~idx : idx.
  - neg = q[1].
- ROM read (stage 2 → 3): synchronous read, mag <= L[addr], neg forwarded.
- Unfold (stage 3 → out):
  - nco_dout <= neg ? (2^(DATA_W-1)-1 - mag) : (2^(DATA_W-1) + mag).
  - Range is 0x0000..0xFFFF with no overflow; the waveform is symmetric about 0x7FFF.5.
- A valid bit travels with each stage. The pipeline advances every clock regardless of tick.

## Timing
- Reset values:
  - phase_q, ftw_act, shadow, cnt = 0
  - ftw_pend = 0
  - all stage valids = 0
  - nco_valid = 0
  - nco_dout = 2^(DATA_W-1) (0x8000), so the modulator idles at 50% density
- Reset asserts asynchronously, with no clock required. In-flight samples are discarded.
- Latency: tick during cycle k gives nco_dout updated at the end of cycle k+2, with nco_valid high during cycle k+3 only. This is 3 clocks.
- Throughput: one sample per tick, including div=0.
- nco_dout holds its value between valid pulses.
- ftw_pend rises the cycle after ftw_wr and falls the cycle after the applying tick.

## Test plan
- **Reset and idle:** hold nco_rst with no clock edges → nco_dout=0x8000, nco_valid=0, ftw_pend=0. Release with ftw=0, div=0 → nco_valid high every cycle from the 4th clock, nco_dout=0x8065 constant (L[0]=0x65).
- **Quadrant unfold:** ftw_wr with 0x400000, div=0 → after the apply tick, a repeating sequence 0x8065, 0xFFFF, 0x7F9A, 0x0000.
- **Divider:** div=9 → nco_valid pulses exactly 10 clocks apart, each 3 clocks after its tick. Changing div from 9 to 2 at cnt=5 → next tick on the following clock.
- **Shadow tuning word:** ftw_wr mid-interval → ftw_pend=1 until the next tick; that tick's increment uses the old word, the next one uses the new word. ftw_wr on a tick cycle → ftw_pend stays 1.
- **Wrap and clear:** ftw=0xFFFFFF → phase decrements by 1 per tick, wrapping 0 → 0xFFFFFF. phase_clr coincident with tick → phase_q=0 next cycle; the captured sample uses the pre-clear phase.
- **Reset mid-operation:** assert nco_rst one clock after a tick → nco_dout=0x8000 immediately, and no nco_valid pulse for the in-flight sample.

Source files
------------

// File: rtl/sin_nco.sv
// sin_nco -- quarter-wave-LUT sine numerically controlled oscillator.
//
// Produces an unsigned offset-binary sine sample stream for a first-order
// sigma-delta modulator. An internal rate divider produces sample ticks. On
// each tick the phase accumulator advances by the active tuning word. The
// phase is folded onto a quarter-wave table and unfolded to a full-scale code.
// The quarter-wave table is computed at elaboration from the closed-form
// definition, so the ROM needs no external image.
//
// Ports:
//   nco_clk    single clock, shared with the modulator
//   nco_rst    asynchronous active-high reset
//   ftw        frequency tuning word (phase increment per tick)
//   ftw_wr     one-cycle strobe; loads ftw into the shadow register
//   div        a tick occurs every div+1 clocks
//   phase_clr  one-cycle strobe; zeroes the phase accumulator
//   ftw_pend   shadow word written but not yet applied
//   nco_dout   offset-binary sine sample, mid-scale 2^(DATA_W-1), held between ticks
//   nco_valid  one-cycle pulse when nco_dout takes a new sample
module sin_nco #(
    parameter int    DATA_W   = 16,
    parameter int    PHASE_W  = 24,
    parameter int    LUT_AW   = 8,
    parameter int    DIV_W    = 8,
    parameter string LUT_FILE = "sin_quarter.hex"
) (
    input  logic               nco_clk,
    input  logic               nco_rst,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               ftw_wr,
    input  logic [DIV_W-1:0]   div,
    input  logic               phase_clr,
    output logic               ftw_pend,
    output logic [DATA_W-1:0]  nco_dout,
    output logic               nco_valid
);

    localparam int  LUT_N   = 2 ** LUT_AW;
    localparam real HALF_PI = 1.5707963267948966;
    localparam logic [DATA_W-1:0] MID_SCALE = {1'b1, {(DATA_W-1){1'b0}}};

    // L[i] = round((2^(DATA_W-1)-1) * sin(pi/2 * (i+0.5) / 2^LUT_AW)).
    // The half-step offset keeps both quadrant endpoints off the table, so
    // the fold never repeats a sample at a quadrant boundary.
    function automatic logic [LUT_N-1:0][DATA_W-2:0] make_lut();
        logic [LUT_N-1:0][DATA_W-2:0] tbl;
        real amp;
        real ang;
        int  val;
        tbl = '0;
        amp = real'((32'd1 << (DATA_W - 1)) - 32'd1);
        for (int i = 0; i < LUT_N; i++) begin
            ang    = HALF_PI * (real'(i) + 0.5) / real'(LUT_N);
            val    = $rtoi(amp * $sin(ang) + 0.5);
            tbl[i] = val[DATA_W-2:0];
        end
        return tbl;
    endfunction

    localparam logic [LUT_N-1:0][DATA_W-2:0] LUT = make_lut();

    // Negative half maps to (2^(DATA_W-1)-1) - mag, which is simply ~mag in
    // DATA_W-1 bits; positive half maps to 2^(DATA_W-1) + mag. Neither can
    // overflow, and the result is symmetric about mid-scale minus one half.
    function automatic logic [DATA_W-1:0] unfold(input logic neg,
                                                 input logic [DATA_W-2:0] mag);
        logic [DATA_W-1:0] res;
        if (neg) begin
            res = {1'b0, ~mag};
        end else begin
            res = {1'b1, mag};
        end
        return res;
    endfunction

    // The table is generated internally; any other image name cannot be honoured.
    if (LUT_FILE != "sin_quarter.hex") begin : g_lut_file_check
        $error("sin_nco: quarter-wave table is built in, LUT_FILE override unsupported");
    end

    logic [DIV_W-1:0]   cnt_r;
    logic               tick_s;
    logic [PHASE_W-1:0] phase_r;
    logic [PHASE_W-1:0] ftw_act_r;
    logic [PHASE_W-1:0] shadow_r;
    logic [LUT_AW+1:0]  s1_phase_r;     // quadrant + table index bits of the captured phase
    logic               s1_valid_r;
    logic [1:0]         fold_q_s;
    logic [LUT_AW-1:0]  fold_idx_s;
    logic [LUT_AW-1:0]  fold_addr_s;
    logic               fold_neg_s;
    logic [DATA_W-2:0]  rom_mag_r;
    logic               rom_neg_r;
    logic               rom_valid_r;

    // Tick whenever the counter has reached div; >= keeps a lowered div from stalling.
    always_comb begin
        tick_s = (cnt_r >= div);
    end

    // Sample-rate divider counter.
    always_ff @(posedge nco_clk or posedge nco_rst) begin
        if (nco_rst) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

    // Phase accumulator and stage-1 capture; a clear wins over the increment
    // but the coincident tick still captures the pre-clear phase.
    always_ff @(posedge nco_clk or posedge nco_rst) begin
        if (nco_rst) begin
            phase_r    <= {PHASE_W{1'b0}};
            s1_phase_r <= {(LUT_AW+2){1'b0}};
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= tick_s;
            if (tick_s) begin
                s1_phase_r <= phase_r[PHASE_W-1 -: LUT_AW+2];
            end
            if (phase_clr) begin
                phase_r <= {PHASE_W{1'b0}};
            end else if (tick_s) begin
                phase_r <= phase_r + ftw_act_r;
            end
        end
    end

    // Double-buffered tuning word: the tick that applies the shadow still
    // increments with the old active word; a write on that same tick keeps
    // the pending flag set for the newly written word.
    always_ff @(posedge nco_clk or posedge nco_rst) begin
        if (nco_rst) begin
            shadow_r  <= {PHASE_W{1'b0}};
            ftw_act_r <= {PHASE_W{1'b0}};
            ftw_pend  <= 1'b0;
        end else begin
            if (ftw_wr) begin
                shadow_r <= ftw;
            end
            if (tick_s && ftw_pend) begin
                ftw_act_r <= shadow_r;
            end
            if (ftw_wr) begin
                ftw_pend <= 1'b1;
            end else if (tick_s) begin
                ftw_pend <= 1'b0;
            end
        end
    end

    // Fold the captured phase onto the quarter-wave table: odd quadrants run
    // the table backwards, the upper half-cycle is negated.
    always_comb begin
        fold_q_s   = s1_phase_r[LUT_AW+1 -: 2];
        fold_idx_s = s1_phase_r[LUT_AW-1:0];
        fold_neg_s = fold_q_s[1];
        if (fold_q_s[0]) begin
            fold_addr_s = ~fold_idx_s;
        end else begin
            fold_addr_s = fold_idx_s;
        end
    end

    // Synchronous ROM read with the sign forwarded alongside.
    always_ff @(posedge nco_clk or posedge nco_rst) begin
        if (nco_rst) begin
            rom_mag_r   <= {(DATA_W-1){1'b0}};
            rom_neg_r   <= 1'b0;
            rom_valid_r <= 1'b0;
        end else begin
            rom_mag_r   <= LUT[fold_addr_s];
            rom_neg_r   <= fold_neg_s;
            rom_valid_r <= s1_valid_r;
        end
    end

    // Output register: updates only on a valid sample so the modulator sees a held value.
    always_ff @(posedge nco_clk or posedge nco_rst) begin
        if (nco_rst) begin
            nco_dout  <= MID_SCALE;
            nco_valid <= 1'b0;
        end else begin
            nco_valid <= rom_valid_r;
            if (rom_valid_r) begin
                nco_dout <= unfold(rom_neg_r, rom_mag_r);
            end
        end
    end

endmodule

// File: tb/tb_sin_nco.sv
// tb_sin_nco -- self-checking bench for sin_nco.
// A table of per-cycle vectors covers reset release, the quadrant unfold and a
// tuning-word change; hand-written sequences cover the divider, shadow word,
// wrap, clear-on-tick and reset mid-operation. Outputs are sampled on the
// falling edge, inputs are driven there too.
module tb_sin_nco;

    logic        nco_clk;
    logic        nco_rst;
    logic [23:0] ftw;
    logic        ftw_wr;
    logic [7:0]  div;
    logic        phase_clr;
    logic        ftw_pend;
    logic [15:0] nco_dout;
    logic        nco_valid;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [23:0] ftw;
        logic        wr;
        logic        valid;
        logic [15:0] dout;
        logic        pend;
    } vec_t;

    vec_t vecs[$];

    sin_nco dut (
        .nco_clk   (nco_clk),
        .nco_rst   (nco_rst),
        .ftw       (ftw),
        .ftw_wr    (ftw_wr),
        .div       (div),
        .phase_clr (phase_clr),
        .ftw_pend  (ftw_pend),
        .nco_dout  (nco_dout),
        .nco_valid (nco_valid)
    );

    initial begin
        nco_clk = 1'b0;
        forever #5 nco_clk = ~nco_clk;
    end

    function automatic vec_t mk(input logic [23:0] f, input logic w, input logic v,
                                input logic [15:0] d, input logic p);
        vec_t r;
        r.ftw   = f;
        r.wr    = w;
        r.valid = v;
        r.dout  = d;
        r.pend  = p;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge nco_clk);
        @(negedge nco_clk);
    endtask

    // Steps until nco_valid is seen; n is the number of clocks taken. held
    // reports whether nco_dout stayed put on every non-valid cycle in between.
    task automatic wait_valid(input int max_cyc, output int n, output logic held);
        logic [15:0] prev;
        prev = nco_dout;
        held = 1'b1;
        n    = 0;
        do begin
            step();
            n++;
            if (!nco_valid && nco_dout !== prev) held = 1'b0;
        end while (!nco_valid && n < max_cyc);
        if (!nco_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_valid: no pulse within %0d clocks", max_cyc);
        end
    endtask

    task automatic wait_pend_low(input int max_cyc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ftw_pend && n < max_cyc);
        if (ftw_pend) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_pend_low: still pending after %0d clocks", max_cyc);
        end
    endtask

    initial begin
        int   n;
        logic held;
        int   quiet;

        // Expected stream: L[0]=0x65, L[127]=0x5A3B, L[128]=0x5AC9, L[255]=0x7FFF.
        vecs.push_back(mk(24'h000000, 1'b0, 1'b0, 16'h8000, 1'b0));
        vecs.push_back(mk(24'h000000, 1'b0, 1'b0, 16'h8000, 1'b0));
        vecs.push_back(mk(24'h000000, 1'b0, 1'b1, 16'h8065, 1'b0));
        vecs.push_back(mk(24'h000000, 1'b0, 1'b1, 16'h8065, 1'b0));
        vecs.push_back(mk(24'h400000, 1'b1, 1'b1, 16'h8065, 1'b1));
        vecs.push_back(mk(24'h400000, 1'b0, 1'b1, 16'h8065, 1'b0));
        vecs.push_back(mk(24'h400000, 1'b0, 1'b1, 16'h8065, 1'b0));
        vecs.push_back(mk(24'h400000, 1'b0, 1'b1, 16'h8065, 1'b0));
        vecs.push_back(mk(24'h400000, 1'b0, 1'b1, 16'h8065, 1'b0));
        vecs.push_back(mk(24'h400000, 1'b0, 1'b1, 16'hFFFF, 1'b0));
        vecs.push_back(mk(24'h400000, 1'b0, 1'b1, 16'h7F9A, 1'b0));
        vecs.push_back(mk(24'h400000, 1'b0, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(24'h400000, 1'b0, 1'b1, 16'h8065, 1'b0));
        vecs.push_back(mk(24'h400000, 1'b0, 1'b1, 16'hFFFF, 1'b0));
        vecs.push_back(mk(24'h200000, 1'b1, 1'b1, 16'h7F9A, 1'b1));
        vecs.push_back(mk(24'h200000, 1'b0, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(24'h200000, 1'b0, 1'b1, 16'h8065, 1'b0));
        vecs.push_back(mk(24'h200000, 1'b0, 1'b1, 16'hFFFF, 1'b0));
        vecs.push_back(mk(24'h200000, 1'b0, 1'b1, 16'h7F9A, 1'b0));
        vecs.push_back(mk(24'h200000, 1'b0, 1'b1, 16'h2536, 1'b0));
        vecs.push_back(mk(24'h200000, 1'b0, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(24'h200000, 1'b0, 1'b1, 16'h25C4, 1'b0));
        vecs.push_back(mk(24'h200000, 1'b0, 1'b1, 16'h8065, 1'b0));
        vecs.push_back(mk(24'h200000, 1'b0, 1'b1, 16'hDAC9, 1'b0));

        nco_rst   = 1'b0;
        ftw       = 24'h000000;
        ftw_wr    = 1'b0;
        div       = 8'd0;
        phase_clr = 1'b0;

        // Asynchronous reset before any clock edge.
        #1 nco_rst = 1'b1;
        #1;
        check("reset dout", nco_dout, 16'h8000);
        check("reset valid", nco_valid, 1'b0);
        check("reset pend", ftw_pend, 1'b0);

        @(negedge nco_clk);
        @(negedge nco_clk);
        nco_rst = 1'b0;

        // Reset release, idle output, quadrant unfold, tuning-word change.
        for (int i = 0; i < vecs.size(); i++) begin
            ftw    = vecs[i].ftw;
            ftw_wr = vecs[i].wr;
            step();
            ftw_wr = 1'b0;
            check($sformatf("vec%0d valid", i), nco_valid, vecs[i].valid);
            check($sformatf("vec%0d dout", i), nco_dout, vecs[i].dout);
            check($sformatf("vec%0d pend", i), ftw_pend, vecs[i].pend);
        end

        // Divider at div=9: pulses 10 clocks apart, output held in between.
        div = 8'd9;
        repeat (12) step();
        wait_valid(40, n, held);
        wait_valid(40, n, held);
        check("div9 gap", n, 10);
        check("div9 hold", held, 1'b1);
        wait_valid(40, n, held);
        check("div9 gap2", n, 10);

        // Shadow word written mid-interval; clear phase first (no tick coincident).
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        step();
        ftw    = 24'h400000;
        ftw_wr = 1'b1;
        step();
        ftw_wr = 1'b0;
        check("shadow pend set", ftw_pend, 1'b1);
        wait_pend_low(20, n);
        check("shadow pend fall", n, 5);
        wait_valid(20, n, held);
        check("tick to valid", n, 2);
        check("shadow sample0", nco_dout, 16'h8065);
        wait_valid(20, n, held);
        check("shadow gap1", n, 10);
        check("shadow old word", nco_dout, 16'hDAC9);
        wait_valid(20, n, held);
        check("shadow gap2", n, 10);
        check("shadow new word", nco_dout, 16'hDA3B);

        // Write while pending, then a second write exactly on the tick cycle.
        step();
        ftw    = 24'h400000;
        ftw_wr = 1'b1;
        step();
        ftw_wr = 1'b0;
        check("pend before tick", ftw_pend, 1'b1);
        repeat (5) step();
        ftw_wr = 1'b1;
        step();
        ftw_wr = 1'b0;
        check("pend after coincident", ftw_pend, 1'b1);
        wait_pend_low(20, n);
        check("pend fall next tick", n, 10);

        // Lower div from 9 to 2 while cnt=5: tick on that clock.
        wait_valid(20, n, held);
        repeat (3) step();
        div = 8'd2;
        wait_valid(20, n, held);
        check("div drop gap", n, 3);
        wait_valid(20, n, held);
        check("div2 gap", n, 3);

        // Clear coincident with a tick at div=0, ftw_act=0x400000.
        div = 8'd0;
        repeat (4) step();
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        step();
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        step();
        step();
        check("clr pre-clear sample", nco_dout, 16'hFFFF);
        step();
        check("clr zero sample", nco_dout, 16'h8065);
        step();
        check("clr resume sample", nco_dout, 16'hFFFF);

        // Decrement by one per tick through the wrap 0 -> 0xFFFFFF.
        ftw    = 24'hFFFFFF;
        ftw_wr = 1'b1;
        step();
        ftw_wr    = 1'b0;
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        repeat (3) step();
        check("wrap phase0", nco_dout, 16'h8065);
        step();
        check("wrap phase ffffff", nco_dout, 16'h7F9A);
        step();
        check("wrap phase fffffe", nco_dout, 16'h7F9A);

        // Reset one clock after a tick: output drops at once, in-flight sample lost.
        div = 8'd20;
        repeat (5) step();
        wait_valid(60, n, held);
        repeat (19) step();
        nco_rst = 1'b1;
        #1;
        check("midrst dout", nco_dout, 16'h8000);
        check("midrst valid", nco_valid, 1'b0);
        check("midrst pend", ftw_pend, 1'b0);
        #1 nco_rst = 1'b0;
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!nco_valid && nco_dout === 16'h8000) quiet++;
        end
        check("midrst no pulse", quiet, 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
